// File: rtl/dual_port_mem_ctrl.sv
// Two-channel (CPU / debug-loader) memory controller: round-robin arbitration, programmable
// wait states, and a CPU-write-protected ROM window with a sticky violation flag.
module dual_port_mem_ctrl #(
    parameter int unsigned     AW          = 16,
    parameter int unsigned     DW          = 8,
    parameter int unsigned     DEPTH_LOG2  = 16,
    parameter int unsigned     WAIT_STATES = 0,
    parameter logic [AW-1:0]   ROM_BASE    = 16'hF000
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          cpu_req,
    input  logic          cpu_rw,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    output logic          rom_viol
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        CH_CPU = 1'b0,
        CH_DBG = 1'b1
    } chan_e;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);
    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;

    state_e          state_q, state_d;
    logic [3:0]      wait_q, wait_d;
    chan_e           chan_q, chan_d;
    chan_e           last_grant_q, last_grant_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            wr_q, wr_d;
    logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic            rom_viol_q, rom_viol_d;

    logic [DW-1:0]   mem_q [0:DEPTH-1];

    logic [DEPTH_LOG2-1:0] mem_idx;
    logic            grant_vld;
    chan_e           grant_ch;
    logic            access_en;
    logic            rom_hit;
    logic            mem_we;

    // On a tie the channel that did not win last time is served.
    always_comb begin
        grant_vld = cpu_req | dbg_req;
        grant_ch  = CH_CPU;
        if (cpu_req && dbg_req) begin
            grant_ch = (last_grant_q == CH_CPU) ? CH_DBG : CH_CPU;
        end else if (dbg_req) begin
            grant_ch = CH_DBG;
        end
    end

    always_comb begin
        mem_idx   = addr_q[DEPTH_LOG2-1:0];
        rom_hit   = (chan_q == CH_CPU) && wr_q && (addr_q >= ROM_BASE);
        access_en = (state_q == ST_BUSY) && (wait_q == 4'd0);
        mem_we    = access_en && wr_q && !rom_hit && !clr;
        cpu_ack   = (state_q == ST_DONE) && (chan_q == CH_CPU);
        dbg_ack   = (state_q == ST_DONE) && (chan_q == CH_DBG);
        cpu_rdata = cpu_rdata_q;
        dbg_rdata = dbg_rdata_q;
        rom_viol  = rom_viol_q;
    end

    // NOTE: every next-state signal takes its held value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        chan_d       = chan_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_d         = wr_q;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        rom_viol_d   = rom_viol_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    state_d      = ST_BUSY;
                    wait_d       = WAIT_LOAD;
                    chan_d       = grant_ch;
                    last_grant_d = grant_ch;
                    if (grant_ch == CH_CPU) begin
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                        wr_d    = ~cpu_rw;
                    end else begin
                        addr_d  = dbg_addr;
                        wdata_d = dbg_wdata;
                        wr_d    = dbg_we;
                    end
                end
            end
            ST_BUSY: begin
                if (wait_q == 4'd0) begin
                    state_d = ST_DONE;
                    if (wr_q) begin
                        if (rom_hit) begin
                            rom_viol_d = 1'b1;
                        end
                    end else if (chan_q == CH_CPU) begin
                        cpu_rdata_d = mem_q[mem_idx];
                    end else begin
                        dbg_rdata_d = mem_q[mem_idx];
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            wait_q       <= 4'd0;
            chan_q       <= CH_CPU;
            last_grant_q <= CH_CPU;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_q         <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
            rom_viol_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            chan_q       <= chan_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_q         <= wr_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
            rom_viol_q   <= rom_viol_d;
        end
    end

    // NOTE: the array is deliberately not reset, so contents survive clr and it maps onto RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_dual_port_mem_ctrl.sv
// Bench for dual_port_mem_ctrl: two instances (0 wait states / full depth, 3 wait states / 256
// words) driven by directed and $urandom traffic, checked against an associative-array model.
module tb_dual_port_mem_ctrl;

    localparam int          WS0  = 0;
    localparam int          WS1  = 3;
    localparam int          DL0  = 16;
    localparam int          DL1  = 8;
    localparam logic [15:0] ROMB = 16'hF000;

    logic             clk = 1'b0;
    logic [1:0]       clr;
    logic [1:0]       cpu_req, cpu_rw, cpu_ack, dbg_req, dbg_we, dbg_ack, rom_viol;
    logic [1:0][15:0] cpu_addr, dbg_addr;
    logic [1:0][7:0]  cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem0 [int];
    logic [7:0] mem1 [int];
    bit         viol_m [2];
    logic [7:0] lrd_m  [2][2];

    always #5 clk = ~clk;

    dual_port_mem_ctrl #(
        .AW(16), .DW(8), .DEPTH_LOG2(DL0), .WAIT_STATES(WS0), .ROM_BASE(ROMB)
    ) u_dut0 (
        .clk(clk), .clr(clr[0]),
        .cpu_req(cpu_req[0]), .cpu_rw(cpu_rw[0]), .cpu_addr(cpu_addr[0]),
        .cpu_wdata(cpu_wdata[0]), .cpu_rdata(cpu_rdata[0]), .cpu_ack(cpu_ack[0]),
        .dbg_req(dbg_req[0]), .dbg_we(dbg_we[0]), .dbg_addr(dbg_addr[0]),
        .dbg_wdata(dbg_wdata[0]), .dbg_rdata(dbg_rdata[0]), .dbg_ack(dbg_ack[0]),
        .rom_viol(rom_viol[0])
    );

    dual_port_mem_ctrl #(
        .AW(16), .DW(8), .DEPTH_LOG2(DL1), .WAIT_STATES(WS1), .ROM_BASE(ROMB)
    ) u_dut1 (
        .clk(clk), .clr(clr[1]),
        .cpu_req(cpu_req[1]), .cpu_rw(cpu_rw[1]), .cpu_addr(cpu_addr[1]),
        .cpu_wdata(cpu_wdata[1]), .cpu_rdata(cpu_rdata[1]), .cpu_ack(cpu_ack[1]),
        .dbg_req(dbg_req[1]), .dbg_we(dbg_we[1]), .dbg_addr(dbg_addr[1]),
        .dbg_wdata(dbg_wdata[1]), .dbg_rdata(dbg_rdata[1]), .dbg_ack(dbg_ack[1]),
        .rom_viol(rom_viol[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ws_of(input int inst);
        return (inst == 0) ? WS0 : WS1;
    endfunction

    // Array index: address modulo the array depth.
    function automatic int idx_of(input int inst, input logic [15:0] a);
        int dl;
        dl = (inst == 0) ? DL0 : DL1;
        return int'(a) % (1 << dl);
    endfunction

    function automatic bit model_has(input int inst, input int idx);
        if (inst == 0) return mem0.exists(idx) != 0;
        return mem1.exists(idx) != 0;
    endfunction

    function automatic logic [7:0] model_get(input int inst, input int idx);
        if (inst == 0) return mem0.exists(idx) ? mem0[idx] : 8'hxx;
        return mem1.exists(idx) ? mem1[idx] : 8'hxx;
    endfunction

    function automatic void model_put(input int inst, input int idx, input logic [7:0] d);
        if (inst == 0) mem0[idx] = d;
        else mem1[idx] = d;
    endfunction

    function automatic void model_clr(input int inst);
        viol_m[inst]    = 1'b0;
        lrd_m[inst][0]  = 8'h00;
        lrd_m[inst][1]  = 8'h00;
    endfunction

    task automatic check_idle_outputs(input int inst, input string tag);
        check($sformatf("i%0d_%s_cpu_ack", inst, tag), cpu_ack[inst], 0);
        check($sformatf("i%0d_%s_dbg_ack", inst, tag), dbg_ack[inst], 0);
        check($sformatf("i%0d_%s_cpu_rdata", inst, tag), cpu_rdata[inst], 0);
        check($sformatf("i%0d_%s_dbg_rdata", inst, tag), dbg_rdata[inst], 0);
        check($sformatf("i%0d_%s_rom_viol", inst, tag), rom_viol[inst], 0);
    endtask

    task automatic do_clr(input int inst);
        clr[inst]     = 1'b1;
        cpu_req[inst] = 1'b0;
        dbg_req[inst] = 1'b0;
        @(negedge clk);
        clr[inst] = 1'b0;
        model_clr(inst);
        check_idle_outputs(inst, "clr");
    endtask

    // One single-channel access, started and finished on a falling edge.
    task automatic access(input int inst, input bit dbg, input bit wr,
                          input logic [15:0] addr, input logic [7:0] wd);
        int cyc;
        bit seen;
        bit other;
        int idx;
        if (dbg) begin
            dbg_addr[inst] = addr; dbg_wdata[inst] = wd; dbg_we[inst] = wr; dbg_req[inst] = 1'b1;
        end else begin
            cpu_addr[inst] = addr; cpu_wdata[inst] = wd; cpu_rw[inst] = !wr; cpu_req[inst] = 1'b1;
        end
        cyc = 0; seen = 1'b0; other = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            seen = dbg ? dbg_ack[inst] : cpu_ack[inst];
            if (dbg ? cpu_ack[inst] : dbg_ack[inst]) other = 1'b1;
        end
        check($sformatf("i%0d_latency", inst), cyc, ws_of(inst) + 2);
        check($sformatf("i%0d_other_ack", inst), other, 0);
        idx = idx_of(inst, addr);
        if (wr) begin
            if (!dbg && addr >= ROMB) viol_m[inst] = 1'b1;
            else model_put(inst, idx, wd);
        end else begin
            lrd_m[inst][dbg] = model_get(inst, idx);
        end
        check($sformatf("i%0d_cpu_rdata@%0h", inst, addr), cpu_rdata[inst], lrd_m[inst][0]);
        check($sformatf("i%0d_dbg_rdata@%0h", inst, addr), dbg_rdata[inst], lrd_m[inst][1]);
        check($sformatf("i%0d_rom_viol", inst), rom_viol[inst], viol_m[inst]);
        cpu_req[inst] = 1'b0;
        dbg_req[inst] = 1'b0;
        @(negedge clk);
        check($sformatf("i%0d_ack_pulse", inst), {30'd0, cpu_ack[inst], dbg_ack[inst]}, 0);
    endtask

    task automatic count_acks(input int inst, input int n, output int acks);
        acks = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (cpu_ack[inst] || dbg_ack[inst]) acks++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         acks;
        int         n;
        int         cyc;
        bit         overlap;
        int         order [4];
        int         when_c [4];
        logic [15:0] a;
        bit         dbg, wr;

        clr = 2'b11; cpu_req = '0; dbg_req = '0; cpu_rw = 2'b11; dbg_we = '0;
        cpu_addr = '0; dbg_addr = '0; cpu_wdata = '0; dbg_wdata = '0;
        repeat (2) @(negedge clk);
        do_clr(0);
        do_clr(1);

        // Debug write then CPU read, zero wait states.
        access(0, 1'b1, 1'b1, 16'h0022, 8'h55);
        access(0, 1'b0, 1'b0, 16'h0022, 8'h00);

        // Three wait states.
        access(1, 1'b1, 1'b1, 16'h0040, 8'hC3);
        access(1, 1'b0, 1'b0, 16'h0040, 8'h00);

        // Both channels held from reset: dbg first, then alternating every WS+3 cycles.
        clr[0] = 1'b1;
        cpu_addr[0] = 16'h0030; cpu_wdata[0] = 8'hA1; cpu_rw[0] = 1'b0; cpu_req[0] = 1'b1;
        dbg_addr[0] = 16'h0040; dbg_wdata[0] = 8'hB2; dbg_we[0] = 1'b1; dbg_req[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        model_clr(0);
        n = 0; cyc = 0; overlap = 1'b0;
        while (n < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cpu_ack[0] && dbg_ack[0]) overlap = 1'b1;
            if (cpu_ack[0] || dbg_ack[0]) begin
                order[n]  = dbg_ack[0] ? 1 : 0;
                when_c[n] = cyc;
                n++;
                if (n == 4) begin
                    cpu_req[0] = 1'b0;
                    dbg_req[0] = 1'b0;
                end
            end
        end
        cpu_req[0] = 1'b0;
        dbg_req[0] = 1'b0;
        check("tie_count", n, 4);
        check("tie_overlap", overlap, 0);
        if (n == 4) begin
            check("tie_order0", order[0], 1);
            check("tie_order1", order[1], 0);
            check("tie_order2", order[2], 1);
            check("tie_order3", order[3], 0);
            check("tie_first", when_c[0], WS0 + 2);
            for (int i = 1; i < 4; i++) check($sformatf("tie_gap%0d", i), when_c[i] - when_c[i-1], WS0 + 3);
        end
        model_put(0, idx_of(0, 16'h0030), 8'hA1);
        model_put(0, idx_of(0, 16'h0040), 8'hB2);
        count_acks(0, 4, acks);
        check("tie_quiet", acks, 0);
        access(0, 1'b0, 1'b0, 16'h0030, 8'h00);
        access(0, 1'b1, 1'b0, 16'h0040, 8'h00);

        // ROM window: CPU write blocked and flagged, debug unrestricted, flag sticky until clr.
        access(0, 1'b1, 1'b1, 16'hFFFC, 8'h57);
        access(0, 1'b0, 1'b1, 16'hFFFC, 8'hAA);
        access(0, 1'b1, 1'b0, 16'hFFFC, 8'h00);
        access(0, 1'b0, 1'b0, 16'hFFFC, 8'h00);
        access(0, 1'b0, 1'b1, 16'hEFFF, 8'h12);
        access(0, 1'b0, 1'b0, 16'hEFFF, 8'h00);
        access(0, 1'b1, 1'b1, 16'hF000, 8'h34);
        access(0, 1'b0, 1'b1, 16'hF000, 8'h99);
        access(0, 1'b0, 1'b0, 16'hF000, 8'h00);
        do_clr(0);

        // clr during BUSY aborts the pending write without an ack.
        access(1, 1'b1, 1'b1, 16'h0100, 8'h22);
        cpu_addr[1] = 16'h0100; cpu_wdata[1] = 8'h11; cpu_rw[1] = 1'b0; cpu_req[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr[1] = 1'b1;
        cpu_req[1] = 1'b0;
        @(negedge clk);
        clr[1] = 1'b0;
        model_clr(1);
        check_idle_outputs(1, "abort");
        count_acks(1, 8, acks);
        check("abort_no_ack", acks, 0);
        access(1, 1'b1, 1'b0, 16'h0100, 8'h00);

        // clr and req in the same cycle: the request is dropped.
        access(1, 1'b1, 1'b1, 16'h0005, 8'h44);
        clr[1] = 1'b1;
        dbg_addr[1] = 16'h0005; dbg_wdata[1] = 8'h99; dbg_we[1] = 1'b1; dbg_req[1] = 1'b1;
        @(negedge clk);
        clr[1] = 1'b0;
        dbg_req[1] = 1'b0;
        model_clr(1);
        count_acks(1, 8, acks);
        check("clr_req_no_ack", acks, 0);
        access(1, 1'b1, 1'b0, 16'h0005, 8'h00);

        // Aliasing with a 256-word array.
        access(1, 1'b1, 1'b1, 16'h0122, 8'h3C);
        access(1, 1'b0, 1'b0, 16'h0022, 8'h00);

        // Random single-channel traffic on both instances.
        for (int inst = 0; inst < 2; inst++) begin
            for (int it = 0; it < 150; it++) begin
                dbg = 1'($urandom_range(0, 1));
                wr  = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 3))
                    0:       a = 16'($urandom_range(0, 65535));
                    1:       a = 16'($urandom_range(0, 63));
                    2:       a = 16'($urandom_range(16'hEFF8, 16'hF007));
                    default: a = 16'($urandom_range(16'hFFF0, 16'hFFFF));
                endcase
                if (!wr && !model_has(inst, idx_of(inst, a))) wr = 1'b1;
                access(inst, dbg, wr, a, 8'($urandom));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
